digit_bcd_converter: RTL and testbench

- Sequential, parametrised binary-to-BCD converter for the 7-segment display path.
- Successor to the fixed two-digit divide/modulo split; replaces combinational /10 and %10 logic with an iterative double-dabble engine, one shift per clock.
- Adds start/busy/done handshake, leading-zero blanking mask, and overflow saturation.
- Sits between the timer/PWM-duty registers and the display scan/segment decoder.

---
 rtl/digit_pkg.sv | 43 ++++
 rtl/digit_bcd_converter_add3.sv | 16 +
 rtl/digit_bcd_converter.sv | 140 ++++++++++++++
 tb/tb_digit_bcd_converter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the binary-to-BCD display converter:
// digit width, FSM state encoding and constant helper functions.
package digit_pkg;

  localparam int DIGIT_W = 4;

  // Converter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // 10^n, used as the overflow threshold for an n-digit display.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Ceiling log2; never returns less than 1 so it can size a register.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  // Decimal digits needed for any w-bit value: ceil(w * 0.302),
  // a slight over-estimate of log10(2) so it never comes up short.
  function automatic int bin_digits(input int w);
    return (w * 302 + 999) / 1000;
  endfunction

endpackage

// File: rtl/digit_bcd_converter_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pure combinational adjust.
  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/digit_bcd_converter.sv
// Iterative binary-to-BCD converter for the 7-segment display path.
// One double-dabble shift per clock, start/busy/done handshake,
// leading-zero blank mask and overflow saturation to all nines.
//
// Handshake: i_start is a request sampled on the rising edge. It is
// accepted only in IDLE or DONE (DONE accepts it for back-to-back
// operation); i_value is captured on that same edge. While o_busy is
// high further requests are ignored. o_done is a single-cycle pulse
// and o_bcd/o_blank/o_ovf are valid from that cycle until the next
// o_done; they never show partial results.
module digit_bcd_converter
  import digit_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_start,
  input  logic [BIN_W-1:0]          i_value,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [DIGIT_W*DIGITS-1:0] o_bcd,
  output logic [DIGITS-1:0]         o_blank,
  output logic                      o_ovf,
  output logic [1:0]                o_state
);

  // Scratch register holds every digit the input can produce plus one
  // guard digit, and never fewer digits than the display shows.
  localparam int NDIG    = bin_digits(BIN_W);
  localparam int SCR_DIG = ((NDIG + 1) > DIGITS) ? (NDIG + 1) : DIGITS;
  localparam int SCR_W   = DIGIT_W * SCR_DIG;
  localparam int SR_W    = SCR_W + BIN_W;
  localparam int OUT_W   = DIGIT_W * DIGITS;
  localparam int CNT_W   = clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Overflow threshold, compared in a widened domain so that a
  // threshold larger than any BIN_W-bit value simply never matches.
  localparam logic [BIN_W+63:0] THRESH_X = {{BIN_W{1'b0}}, pow10(DIGITS)};
  localparam logic [BIN_W+63:0] MAX_X    = {64'd0, {BIN_W{1'b1}}};
  localparam logic              OVF_EN   = (MAX_X >= THRESH_X);

  localparam logic [OUT_W-1:0]  NINES     = {DIGITS{4'h9}};
  localparam logic [DIGITS-1:0] BLANK_RST =
    (BLANK_LZ != 0) ? ~DIGITS'(1) : {DIGITS{1'b0}};

  state_t           state;
  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_adj;
  logic [SR_W-1:0]  sr_next;
  logic [CNT_W-1:0] cnt;
  logic             ovf_cap;
  logic             ovf_now;
  logic [OUT_W-1:0] res;
  logic [DIGITS-1:0] blank_next;
  logic             run_zero;

  assign o_state = state;

  // Per-digit +3 correction on the scratch (BCD) part of the register.
  genvar g;
  generate
    for (g = 0; g < SCR_DIG; g++) begin : g_add3
      bcd_add3 u_add3 (
        .din  (sr[BIN_W + g*DIGIT_W +: DIGIT_W]),
        .dout (sr_adj[BIN_W + g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];
  assign sr_next           = {sr_adj[SR_W-2:0], 1'b0};

  // Result digits as they will stand after the current shift.
  assign res = sr_next[BIN_W +: OUT_W];

  // Overflow test on the value presented for capture.
  assign ovf_now = OVF_EN && ({64'd0, i_value} >= THRESH_X);

  // Leading-zero mask for the result about to be published.
  always_comb begin
    blank_next = '0;
    run_zero   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run_zero      = run_zero & (res[k*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_next[k] = run_zero;
    end
    if ((BLANK_LZ == 0) || ovf_cap) begin
      blank_next = '0;
    end
  end

  // Converter FSM: capture, BIN_W shifts, publish registered results.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      sr      <= '0;
      cnt     <= '0;
      ovf_cap <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_bcd   <= '0;
      o_blank <= BLANK_RST;
      o_ovf   <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state   <= ST_DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_bcd   <= ovf_cap ? NINES : res;
            o_blank <= blank_next;
            o_ovf   <= ovf_cap;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request.
          o_done <= 1'b0;
          if (i_start) begin
            state   <= ST_SHIFT;
            sr      <= {{SCR_W{1'b0}}, i_value};
            cnt     <= '0;
            ovf_cap <= ovf_now;
            o_busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_bcd_converter.sv
// Bench for digit_bcd_converter (BIN_W=14, DIGITS=4): directed vectors
// with hand-computed results, cycle timing, mid-conversion reset, a
// BLANK_LZ=0 instance, and a sampled sweep against a div/mod model.
module tb_digit_bcd_converter;

  localparam int W = 21; // {bcd[15:0], blank[3:0], ovf}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [13:0] value;
  logic        busy, done, ovf;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic [1:0]  state;

  logic        start_b;
  logic [13:0] value_b;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] bcd_b;
  logic [3:0]  blank_b;
  logic [1:0]  state_b;

  digit_bcd_converter #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(1)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_value(value),
    .o_busy(busy), .o_done(done), .o_bcd(bcd), .o_blank(blank),
    .o_ovf(ovf), .o_state(state)
  );

  digit_bcd_converter #(.BIN_W(14), .DIGITS(4), .BLANK_LZ(0)) u_dut_nb (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start_b), .i_value(value_b),
    .o_busy(busy_b), .o_done(done_b), .o_bcd(bcd_b), .o_blank(blank_b),
    .o_ovf(ovf_b), .o_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [15:0] b, input logic [3:0] bl, input logic o);
    exp_q.push_back({b, bl, o});
  endtask

  // Reference model: plain divide/modulo decimal split.
  function automatic logic [W-1:0] ref_exp(input int v);
    logic [15:0] b;
    logic [3:0]  bl;
    logic        z;
    int          d;
    if (v >= 10000) return {16'h9999, 4'b0000, 1'b1};
    b = '0;
    for (int k = 0; k < 4; k++) begin
      d = (v / (10 ** k)) % 10;
      b[k*4 +: 4] = 4'(d);
    end
    bl = 4'b0000;
    z  = 1'b1;
    for (int k = 3; k >= 1; k--) begin
      d = v / (10 ** k);
      z = z && (d == 0);
      bl[k] = z;
    end
    return {b, bl, 1'b0};
  endfunction

  // Monitor: every done pulse pops and checks one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got bcd %0h with empty queue", bcd);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_bcd", 32'(bcd), 32'(mon_e[20:5]));
        check("done_blank", 32'(blank), 32'(mon_e[4:1]));
        check("done_ovf", 32'(ovf), 32'(mon_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int v);
    @(negedge clk);
    start = 1'b1;
    value = 14'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 14'($urandom_range(0, 16383));
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 40 && done_cnt < target; i++) @(posedge clk);
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic run(input int v, input logic [W-1:0] e);
    int target;
    exp_q.push_back(e);
    target = done_cnt + 1;
    issue(v);
    wait_done(target);
  endtask

  // Called just after the accepting edge: cycles 1..14 busy, 15 done.
  task automatic check_timing(input logic [15:0] hold);
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      check("busy_cycle", 32'(busy), 32'(c <= 14));
      check("done_cycle", 32'(done), 32'(c == 15));
      if (c <= 14) check("bcd_hold", 32'(bcd), 32'(hold));
    end
  endtask

  task automatic run_b(input int v, input logic [15:0] eb);
    logic seen;
    @(negedge clk);
    start_b = 1'b1;
    value_b = 14'(v);
    @(posedge clk);
    #1;
    start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        check("nb_bcd", 32'(bcd_b), 32'(eb));
        check("nb_blank", 32'(blank_b), 32'd0);
        check("nb_ovf", 32'(ovf_b), 32'd0);
      end
    end
    check("nb_done_timeout", 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst_n   = 1'b0;
    start   = 1'b0;
    value   = '0;
    start_b = 1'b0;
    value_b = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_blank", 32'(blank), 32'b1110);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_blank_nb", 32'(blank_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1234 with full cycle timing; o_bcd holds reset value until done.
    push(16'h1234, 4'b0000, 1'b0);
    d0 = done_cnt;
    issue(1234);
    check_timing(16'h0000);
    wait_done(d0 + 1);

    // Small values and leading-zero mask.
    run(7,     {16'h0007, 4'b1110, 1'b0});
    run(0,     {16'h0000, 4'b1110, 1'b0});
    run(9999,  {16'h9999, 4'b0000, 1'b0});
    run(12000, {16'h9999, 4'b0000, 1'b1});
    run(10000, {16'h9999, 4'b0000, 1'b1});
    run(16383, {16'h9999, 4'b0000, 1'b1});
    run(10,    {16'h0010, 4'b1100, 1'b0});
    run_b(7, 16'h0007);

    // 42, ignored restart in cycle 5, back-to-back 100 from DONE.
    d0 = done_cnt;
    push(16'h0042, 4'b1100, 1'b0);
    issue(42);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    value = 14'd55;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("in_done_state", 32'(state), 32'd2);
    start = 1'b1;
    value = 14'd100;
    push(16'h0100, 4'b1000, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_timing(16'h0042);
    wait_done(d0 + 2);
    repeat (20) @(posedge clk);
    check("done_count_b2b", 32'(done_cnt), 32'(d0 + 2));

    // 5678 aborted by async reset mid-cycle 8.
    issue(5678);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_blank", 32'(blank), 32'b1110);
    check("abort_ovf", 32'(ovf), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    d0 = done_cnt;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("post_rel_state", 32'(state), 32'd0);
    run(5678, {16'h5678, 4'b0000, 1'b0});

    // Sampled sweep against the div/mod model.
    for (int v = 0; v <= 150; v++) run(v, ref_exp(v));
    for (int v = 9950; v <= 10050; v++) run(v, ref_exp(v));
    for (int v = 16330; v <= 16383; v++) run(v, ref_exp(v));
    for (int v = 151; v < 16330; v += 17) run(v, ref_exp(v));

    repeat (5) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
